// File: rtl/cpu_pkg.sv
// Shared definitions for the operand-fetch stage and its register file.
// Holds the datapath word width, register-index width, instruction
// field positions for the four source operands, and the operand bundle
// type registered toward the ALU.
package cpu_pkg;

  localparam int WORD_W    = 16;
  localparam int REG_IDX_W = 3;
  localparam int N_RD      = 4;

  // Source-index field positions within the instruction word. The imm6
  // and imm8 fields overlap on purpose; every operand is always fetched.
  localparam int RA_LSB  = 3;
  localparam int RA6_LSB = 6;
  localparam int RA8_LSB = 8;
  localparam int RB_LSB  = 0;

  // Read-port slots used by the stage when talking to the register file.
  localparam int P_RA  = 0;
  localparam int P_RA6 = 1;
  localparam int P_RA8 = 2;
  localparam int P_RB  = 3;

  typedef struct packed {
    logic [WORD_W-1:0] instruction;
    logic [WORD_W-1:0] reg_a;
    logic [WORD_W-1:0] reg_a_imm6;
    logic [WORD_W-1:0] reg_a_imm8;
    logic [WORD_W-1:0] reg_b;
    logic              carry;
  } operand_bundle_t;

  function automatic logic [REG_IDX_W-1:0] src_idx(input logic [WORD_W-1:0] instr,
                                                   input int lsb);
    return instr[lsb +: REG_IDX_W];
  endfunction

endpackage

// File: rtl/regfile_bypass.sv
// General register file with write-to-read bypass.
// Ports:
//   clk, rst_n        clock, async active-low reset (clears every register)
//   we, waddr, wdata  single write port
//   raddr[N_RD]       combinational read addresses
//   rdata[N_RD]       read data; returns wdata when the same cycle writes
//                     the addressed register
// With R0_ZERO != 0 register 0 discards writes and always reads as zero.
module regfile_bypass
  import cpu_pkg::*;
#(
  parameter int NREGS   = 8,
  parameter int R0_ZERO = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            we,
  input  logic [REG_IDX_W-1:0]            waddr,
  input  logic [WORD_W-1:0]               wdata,
  input  logic [N_RD-1:0][REG_IDX_W-1:0]  raddr,
  output logic [N_RD-1:0][WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem_q [NREGS];
  logic              wr_ok;

  // A write to a hard-wired zero register is dropped entirely, so mem_q[0]
  // stays at its reset value and plain reads of index 0 return zero.
  assign wr_ok = we && !((R0_ZERO != 0) && (waddr == '0));

  // NOTE: the array is reset because the architecture defines every
  // register as zero after reset; this costs a reset net per flop, which is
  // why storage arrays are normally left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      // NOTE: non-blocking assignment so every reader in this edge sees the
      // pre-edge value; blocking here would create order-dependent races.
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    // NOTE: a default for every output bit before any branch keeps this a
    // pure combinational block; a missed path would infer a latch.
    rdata = '0;
    for (int p = 0; p < N_RD; p++) begin
      if (wr_ok && (waddr == raddr[p])) rdata[p] = wdata;
      else                              rdata[p] = mem_q[raddr[p]];
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage in front of the ALU.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready/in_instr      instruction input handshake
//   out_valid/out_ready             operand bundle output handshake
//   instruction, regA, regA_imm6,
//   regA_imm8, regB, carry          registered operand bundle
//   wb_en/wb_addr/wb_data           register write-back (never stalled)
//   wb_carry_en/wb_carry            carry flag write-back
// A single output register gives one-cycle latency and full throughput.
// While the bundle is stalled, its operands are re-read every cycle from
// the held instruction's indices so write-backs keep it current.
module alu_operand_stage
  import cpu_pkg::*;
#(
  parameter int NREGS   = 8,
  parameter int R0_ZERO = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_W-1:0]    in_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_W-1:0]    instruction,
  output logic [WORD_W-1:0]    regA,
  output logic [WORD_W-1:0]    regA_imm6,
  output logic [WORD_W-1:0]    regA_imm8,
  output logic [WORD_W-1:0]    regB,
  output logic                 carry,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_addr,
  input  logic [WORD_W-1:0]    wb_data,
  input  logic                 wb_carry_en,
  input  logic                 wb_carry
);

  operand_bundle_t bundle_q, bundle_d;
  logic            valid_q, valid_d;
  logic            carry_flag_q;

  logic                           accept;
  logic                           stall;
  logic                           carry_byp;
  logic [WORD_W-1:0]              rd_instr;
  logic [N_RD-1:0][REG_IDX_W-1:0] raddr;
  logic [N_RD-1:0][WORD_W-1:0]    rdata;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign stall    = valid_q && !out_ready;

  // During a stall the read ports look at the held instruction, which turns
  // the normal bypassed read into the stall-refresh path for free.
  assign rd_instr = stall ? bundle_q.instruction : in_instr;

  assign raddr[P_RA]  = src_idx(rd_instr, RA_LSB);
  assign raddr[P_RA6] = src_idx(rd_instr, RA6_LSB);
  assign raddr[P_RA8] = src_idx(rd_instr, RA8_LSB);
  assign raddr[P_RB]  = src_idx(rd_instr, RB_LSB);

  assign carry_byp = wb_carry_en ? wb_carry : carry_flag_q;

  regfile_bypass #(
    .NREGS   (NREGS),
    .R0_ZERO (R0_ZERO)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wb_en),
    .waddr (wb_addr),
    .wdata (wb_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_comb begin
    bundle_d = bundle_q;
    valid_d  = valid_q;
    if (accept) begin
      bundle_d.instruction = in_instr;
      valid_d              = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    // Accept and stall are mutually exclusive (in_ready is low in a stall),
    // and both load fresh operands from the read ports.
    if (accept || stall) begin
      bundle_d.reg_a      = rdata[P_RA];
      bundle_d.reg_a_imm6 = rdata[P_RA6];
      bundle_d.reg_a_imm8 = rdata[P_RA8];
      bundle_d.reg_b      = rdata[P_RB];
      bundle_d.carry      = carry_byp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bundle_q     <= '0;
      valid_q      <= 1'b0;
      carry_flag_q <= 1'b0;
    end else begin
      bundle_q <= bundle_d;
      valid_q  <= valid_d;
      if (wb_carry_en) carry_flag_q <= wb_carry;
    end
  end

  assign out_valid   = valid_q;
  assign instruction = bundle_q.instruction;
  assign regA        = bundle_q.reg_a;
  assign regA_imm6   = bundle_q.reg_a_imm6;
  assign regA_imm8   = bundle_q.reg_a_imm8;
  assign regB        = bundle_q.reg_b;
  assign carry       = bundle_q.carry;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: dut0 has an ordinary R0, dut1 a hard-wired
// zero R0; both see the same stimulus.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready;
  logic [15:0] in_instr;
  logic        wb_en, wb_carry_en, wb_carry;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;

  logic        in_ready0, out_valid0, carry0;
  logic [15:0] instr0, ra0, ra60, ra80, rb0;
  logic        in_ready1, out_valid1, carry1;
  logic [15:0] instr1, ra1, ra61, ra81, rb1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.NREGS(8), .R0_ZERO(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_instr(in_instr), .out_valid(out_valid0), .out_ready(out_ready),
    .instruction(instr0), .regA(ra0), .regA_imm6(ra60), .regA_imm8(ra80),
    .regB(rb0), .carry(carry0), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_carry_en(wb_carry_en), .wb_carry(wb_carry)
  );

  alu_operand_stage #(.NREGS(8), .R0_ZERO(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_instr(in_instr), .out_valid(out_valid1), .out_ready(out_ready),
    .instruction(instr1), .regA(ra1), .regA_imm6(ra61), .regA_imm8(ra81),
    .regB(rb1), .carry(carry1), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_carry_en(wb_carry_en), .wb_carry(wb_carry)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then return 1 ns after
  // the following rising edge so outputs can be sampled.
  task automatic cycle(input logic iv, input logic [15:0] ins, input logic ordy,
                       input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic ce, input logic c);
    @(negedge clk);
    in_valid = iv; in_instr = ins; out_ready = ordy;
    wb_en = we; wb_addr = wa; wb_data = wd; wb_carry_en = ce; wb_carry = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_bundle0(input string tag, input logic v, input logic [15:0] ins,
                               input logic [15:0] a, input logic [15:0] a6,
                               input logic [15:0] a8, input logic [15:0] b, input logic c);
    check({tag, ".out_valid"}, {31'd0, out_valid0}, {31'd0, v});
    check({tag, ".instruction"}, {16'd0, instr0}, {16'd0, ins});
    check({tag, ".regA"}, {16'd0, ra0}, {16'd0, a});
    check({tag, ".regA_imm6"}, {16'd0, ra60}, {16'd0, a6});
    check({tag, ".regA_imm8"}, {16'd0, ra80}, {16'd0, a8});
    check({tag, ".regB"}, {16'd0, rb0}, {16'd0, b});
    check({tag, ".carry"}, {31'd0, carry0}, {31'd0, c});
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        ce;
    logic        c;
    logic [15:0] ins;
    logic [15:0] a, a6, a8, b;
    logic        ec;
  } vec_t;

  vec_t vecs [4];

  initial begin
    // Register state entering the table: R0=10, R1=5, R3=99, others 0, flag 0.
    vecs[0] = '{1'b0, 3'd0, 16'd0,      1'b0, 1'b0, 16'h8001, 16'd10, 16'd10, 16'd10,  16'd5,      1'b0};
    vecs[1] = '{1'b1, 3'd1, 16'd177,    1'b1, 1'b1, 16'h80C1, 16'd10, 16'd99, 16'd10,  16'd177,    1'b1};
    vecs[2] = '{1'b0, 3'd0, 16'd0,      1'b0, 1'b0, 16'h0118, 16'd99, 16'd0,  16'd177, 16'd10,     1'b1};
    vecs[3] = '{1'b1, 3'd4, 16'h1234,   1'b1, 1'b0, 16'h0024, 16'h1234, 16'd10, 16'd10, 16'h1234,  1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_instr = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; wb_carry_en = 1'b0; wb_carry = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_bundle0("reset", 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
    check("reset.in_ready", {31'd0, in_ready0}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload registers through the write-back port only.
    cycle(1'b0, 16'd0, 1'b1, 1'b1, 3'd1, 16'd5,  1'b0, 1'b0);
    cycle(1'b0, 16'd0, 1'b1, 1'b1, 3'd0, 16'd10, 1'b0, 1'b0);
    cycle(1'b0, 16'd0, 1'b1, 1'b1, 3'd3, 16'd99, 1'b0, 1'b0);
    check("idle.out_valid", {31'd0, out_valid0}, 32'd0);

    // Back-to-back stream: one accept per cycle, checked in order.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, vecs[i].ins, 1'b1, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ce, vecs[i].c);
      check_bundle0($sformatf("vec%0d", i), 1'b1, vecs[i].ins, vecs[i].a, vecs[i].a6,
                    vecs[i].a8, vecs[i].b, vecs[i].ec);
      if (i == 0) begin
        // Hard-wired R0: the earlier R0=10 write was discarded.
        check("r0z.vec0.regA", {16'd0, ra1}, 32'd0);
        check("r0z.vec0.regA_imm8", {16'd0, ra81}, 32'd0);
        check("r0z.vec0.regB", {16'd0, rb1}, 32'd5);
      end
    end

    // Drain: valid drops, data holds.
    cycle(1'b0, 16'hDEAD, 1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
    check_bundle0("drain", 1'b0, 16'h0024, 16'h1234, 16'd10, 16'd10, 16'h1234, 1'b0);

    // R0 write bypassed in the accept cycle, then read from the array.
    cycle(1'b1, 16'h0000, 1'b1, 1'b1, 3'd0, 16'hFFFF, 1'b0, 1'b0);
    check("r0.byp.dut0.regA", {16'd0, ra0}, 32'hFFFF);
    check("r0.byp.dut1.regA", {16'd0, ra1}, 32'd0);
    check("r0.byp.dut1.regB", {16'd0, rb1}, 32'd0);
    cycle(1'b1, 16'h0000, 1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
    check("r0.rd.dut0.regB", {16'd0, rb0}, 32'hFFFF);
    check("r0.rd.dut1.regA_imm6", {16'd0, ra61}, 32'd0);

    // Stall refresh: hold instr 0x0001 (regB <- R1=177, others R0=FFFF).
    cycle(1'b1, 16'h0001, 1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
    check_bundle0("stall.load", 1'b1, 16'h0001, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd177, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_instr = 16'h0002; out_ready = 1'b0;
    wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'd42; wb_carry_en = 1'b1; wb_carry = 1'b1;
    #1;
    check("stall.in_ready", {31'd0, in_ready0}, 32'd0);
    @(posedge clk);
    #1;
    check_bundle0("stall.refresh", 1'b1, 16'h0001, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd42, 1'b1);
    cycle(1'b1, 16'h0002, 1'b0, 1'b1, 3'd5, 16'd7, 1'b1, 1'b0);
    check_bundle0("stall.carry0", 1'b1, 16'h0001, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd42, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
    check("stall.drain.out_valid", {31'd0, out_valid0}, 32'd0);

    // Reset asserted mid-cycle with a valid bundle held.
    cycle(1'b1, 16'h0001, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
    check("mrst.pre.out_valid", {31'd0, out_valid0}, 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_bundle0("mrst", 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("mrst.in_ready", {31'd0, in_ready0}, 32'd1);
    // Register file cleared as well: R1 and R0 read back as zero.
    cycle(1'b1, 16'h0001, 1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
    check_bundle0("mrst.fetch", 1'b1, 16'h0001, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
